// File: rtl/ioreg_write_sequencer.sv
// Script engine that replays stored {addr, data, delay} entries onto the IO-register bus
// with a setup / strobe / hold write cycle, optional post-write wait, looping and abort.
module ioreg_write_sequencer #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 4,
  parameter int DLY_W     = 12,
  parameter int PRESCALE  = 4,
  parameter int WE_CYCLES = 2
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_CFG_WE,
  input  logic [IDX_W-1:0] I_CFG_IDX,
  input  logic [15:0]      I_CFG_ADDR,
  input  logic [7:0]       I_CFG_DATA,
  input  logic [DLY_W-1:0] I_CFG_DLY,
  input  logic [IDX_W:0]   I_LEN,
  input  logic             I_START,
  input  logic             I_LOOP,
  input  logic             I_ABORT,
  output logic [15:0]      O_IOREG_ADDR,
  output logic [7:0]       O_IOREG_DATA,
  output logic             O_IOREG_DATA_OE,
  output logic             O_IOREG_WE_L,
  output logic             O_IOREG_RE_L,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [IDX_W-1:0] O_IDX,
  output logic [2:0]       O_DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4,
    S_END    = 3'd5
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]  STB_LAST  = SW'(WE_CYCLES - 1);
  localparam logic [IDX_W:0] DEPTH_LEN = (IDX_W + 1)'(DEPTH);

  logic [15:0]      ram_addr [DEPTH];
  logic [7:0]       ram_data [DEPTH];
  logic [DLY_W-1:0] ram_dly  [DEPTH];

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [IDX_W:0]   len, len_d;
  logic [SW-1:0]    stb_cnt, stb_d;
  logic [PW-1:0]    pre_cnt, pre_d;
  logic [DLY_W-1:0] dly_cnt, dly_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             oe_q, oe_d;
  logic             we_l_q, we_l_d;
  logic             done_q, done_d;
  logic             advance;

  logic [IDX_W-1:0] fetch_idx;
  logic             bypass;
  logic [15:0]      ent_addr;
  logic [7:0]       ent_data;
  logic [DLY_W-1:0] cur_dly;
  logic [IDX_W:0]   len_in;
  logic             last_entry;

  // Script RAM has no reset; writes only land while idle.
  always_ff @(posedge I_CLK) begin
    if (I_CFG_WE && state == S_IDLE) begin
      ram_addr[I_CFG_IDX] <= I_CFG_ADDR;
      ram_data[I_CFG_IDX] <= I_CFG_DATA;
      ram_dly[I_CFG_IDX]  <= I_CFG_DLY;
    end
  end

  // A start can coincide with a config write to the first entry, so forward it.
  assign fetch_idx  = (state == S_HOLD || state == S_WAIT) ? idx + 1'b1 : '0;
  assign bypass     = (state == S_IDLE) && I_CFG_WE && (I_CFG_IDX == fetch_idx);
  assign ent_addr   = bypass ? I_CFG_ADDR : ram_addr[fetch_idx];
  assign ent_data   = bypass ? I_CFG_DATA : ram_data[fetch_idx];
  assign cur_dly    = ram_dly[idx];
  assign len_in     = (I_LEN > DEPTH_LEN) ? DEPTH_LEN : I_LEN;
  assign last_entry = ({1'b0, idx} + (IDX_W + 1)'(1)) >= len;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    len_d   = len;
    stb_d   = stb_cnt;
    pre_d   = pre_cnt;
    dly_d   = dly_cnt;
    addr_d  = addr_q;
    data_d  = data_q;
    oe_d    = oe_q;
    we_l_d  = we_l_q;
    done_d  = 1'b0;
    advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (I_START && !I_ABORT) begin
          if (len_in != '0) begin
            state_d = S_SETUP;
            len_d   = len_in;
            idx_d   = '0;
            addr_d  = ent_addr;
            data_d  = ent_data;
            oe_d    = 1'b1;
            we_l_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        stb_d   = '0;
        we_l_d  = 1'b0;
      end
      S_STROBE: begin
        if (stb_cnt == STB_LAST) begin
          state_d = S_HOLD;
          we_l_d  = 1'b1;
        end else begin
          stb_d = stb_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (cur_dly != '0) begin
          state_d = S_WAIT;
          oe_d    = 1'b0;
          dly_d   = cur_dly;
          pre_d   = '0;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        // One delay tick per PRESCALE cycles; leave on the last tick.
        if (pre_cnt == PRE_LAST) begin
          pre_d = '0;
          if (dly_cnt == DLY_W'(1)) advance = 1'b1;
          else                      dly_d   = dly_cnt - 1'b1;
        end else begin
          pre_d = pre_cnt + 1'b1;
        end
      end
      S_END: begin
        if (I_LOOP) begin
          state_d = S_SETUP;
          idx_d   = '0;
          addr_d  = ent_addr;
          data_d  = ent_data;
          oe_d    = 1'b1;
          we_l_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (last_entry) begin
        state_d = S_END;
        oe_d    = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_SETUP;
        idx_d   = idx + 1'b1;
        addr_d  = ent_addr;
        data_d  = ent_data;
        oe_d    = 1'b1;
        we_l_d  = 1'b1;
      end
    end

    if (I_ABORT && state != S_IDLE) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      we_l_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state   <= S_IDLE;
      idx     <= '0;
      len     <= '0;
      stb_cnt <= '0;
      pre_cnt <= '0;
      dly_cnt <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      we_l_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      len     <= len_d;
      stb_cnt <= stb_d;
      pre_cnt <= pre_d;
      dly_cnt <= dly_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      we_l_q  <= we_l_d;
      done_q  <= done_d;
    end
  end

  assign O_IOREG_ADDR    = addr_q;
  assign O_IOREG_DATA    = data_q;
  assign O_IOREG_DATA_OE = oe_q;
  assign O_IOREG_WE_L    = we_l_q;
  assign O_IOREG_RE_L    = 1'b1;
  assign O_BUSY          = (state != S_IDLE);
  assign O_DONE          = done_q;
  assign O_IDX           = idx;
  assign O_DBG_STATE     = state;

endmodule
